cfc_param_ckpt_rat: RTL

//  Parametrised copy-free checkpoint rename table: speculative RAT held in NUM_CKPT slots,

---
 rtl/cfc_param_ckpt_rat_if.sv | 52 +++++
 rtl/cfc_param_ckpt_rat.sv | 124 ++++++++++++
 2 files changed

// File: rtl/cfc_param_ckpt_rat_if.sv
// cfc_param_ckpt_rat_if: dispatch/ROB/FRL/CDB bundle for the checkpoint rename table
interface cfc_param_ckpt_rat_if #(
  parameter int NUM_CKPT = 8,
  parameter int NUM_AREG = 32,
  parameter int PREG_W = 6,
  parameter int TAG_W = 5,
  parameter int FRL_W = 5
);
  localparam int AREG_W = $clog2(NUM_AREG);
  localparam int CNT_W = $clog2(NUM_CKPT) + 1;
  logic Dis_InstValid;
  logic Dis_CfcBranch;
  logic [TAG_W-1:0] Dis_CfcBranchTag;
  logic [AREG_W-1:0] Dis_CfcRsAddr;
  logic [AREG_W-1:0] Dis_CfcRtAddr;
  logic [AREG_W-1:0] Dis_CfcRdAddr;
  logic Dis_CfcRegWrite;
  logic [PREG_W-1:0] Dis_CfcNewRdPhyAddr;
  logic [PREG_W-1:0] Cfc_RsPhyAddr;
  logic [PREG_W-1:0] Cfc_RtPhyAddr;
  logic [PREG_W-1:0] Cfc_RdPhyAddr;
  logic Cfc_Full;
  logic Cfc_Busy;
  logic [TAG_W-1:0] Rob_TopPtr;
  logic Rob_Commit;
  logic [AREG_W-1:0] Rob_CommitRdAddr;
  logic Rob_CommitRegWrite;
  logic [PREG_W-1:0] Rob_CommitCurrPhyAddr;
  logic [FRL_W-1:0] Frl_HeadPtr;
  logic [FRL_W-1:0] Cfc_FrlHeadPtr;
  logic [TAG_W-1:0] Cfc_RobTag;
  logic Cdb_Flush;
  logic [TAG_W-1:0] Cdb_RobTag;
  logic [CNT_W-1:0] Cfc_CkptCount;
  logic Cfc_FlushMiss;
  modport master (
    output Dis_InstValid, Dis_CfcBranch, Dis_CfcBranchTag, Dis_CfcRsAddr, Dis_CfcRtAddr,
           Dis_CfcRdAddr, Dis_CfcRegWrite, Dis_CfcNewRdPhyAddr, Rob_TopPtr, Rob_Commit,
           Rob_CommitRdAddr, Rob_CommitRegWrite, Rob_CommitCurrPhyAddr, Frl_HeadPtr,
           Cdb_Flush, Cdb_RobTag,
    input  Cfc_RsPhyAddr, Cfc_RtPhyAddr, Cfc_RdPhyAddr, Cfc_Full, Cfc_Busy, Cfc_FrlHeadPtr,
           Cfc_RobTag, Cfc_CkptCount, Cfc_FlushMiss
  );
  modport slave (
    input  Dis_InstValid, Dis_CfcBranch, Dis_CfcBranchTag, Dis_CfcRsAddr, Dis_CfcRtAddr,
           Dis_CfcRdAddr, Dis_CfcRegWrite, Dis_CfcNewRdPhyAddr, Rob_TopPtr, Rob_Commit,
           Rob_CommitRdAddr, Rob_CommitRegWrite, Rob_CommitCurrPhyAddr, Frl_HeadPtr,
           Cdb_Flush, Cdb_RobTag,
    output Cfc_RsPhyAddr, Cfc_RtPhyAddr, Cfc_RdPhyAddr, Cfc_Full, Cfc_Busy, Cfc_FrlHeadPtr,
           Cfc_RobTag, Cfc_CkptCount, Cfc_FlushMiss
  );
endinterface

// File: rtl/cfc_param_ckpt_rat.sv
// cfc_param_ckpt_rat: copy-free checkpoint rename table over a retirement RAT.
// Define CFC_COMMIT_FWD_EN to forward a same-cycle commit into RRAT-resolved lookups.
module cfc_param_ckpt_rat #(
  parameter int NUM_CKPT = 8,
  parameter int NUM_AREG = 32,
  parameter int PREG_W = 6,
  parameter int TAG_W = 5,
  parameter int FRL_W = 5
) (
  input logic clk,
  input logic resetb,
  cfc_param_ckpt_rat_if.slave bus
);
  localparam int AREG_W = $clog2(NUM_AREG);
  localparam int CW = $clog2(NUM_CKPT);
  typedef enum logic {NORMAL, RECOVER} state_t;
  state_t state, state_nx;
  logic [CW-1:0] head, tail, m;
  logic [CW:0] count;
  logic [NUM_CKPT-1:0] valid, kill;
  logic [TAG_W-1:0] tag [NUM_CKPT];
  logic [FRL_W-1:0] frl [NUM_CKPT];
  logic [NUM_AREG-1:0] dfa [NUM_CKPT];
  logic [PREG_W-1:0] tbl [NUM_CKPT][NUM_AREG];
  logic [PREG_W-1:0] rrat [NUM_AREG];
  logic [AREG_W-1:0] la [3];
  logic [PREG_W-1:0] lr [3];
  logic [PREG_W-1:0] lq [3];
  logic acc, rel, ckpt, full, hit, flush_hit, fwd, miss;
  assign full = count == (CW+1)'(NUM_CKPT - 1);
  assign acc = bus.Dis_InstValid & (state == NORMAL) & ~bus.Cdb_Flush;
  assign rel = bus.Rob_Commit & (count != '0) & (bus.Rob_TopPtr == tag[tail]);
  assign ckpt = acc & bus.Dis_CfcBranch & (~full | rel);
  assign flush_hit = bus.Cdb_Flush & hit;
`ifdef CFC_COMMIT_FWD_EN
  assign fwd = bus.Rob_Commit & bus.Rob_CommitRegWrite;
`else
  assign fwd = 1'b0;
`endif
  always_comb begin
    hit = 1'b0;
    m = head;
    for (int k = 0; k < NUM_CKPT; k++)
      if (valid[k] && tag[k] == bus.Cdb_RobTag) begin
        hit = 1'b1;
        m = CW'(k);
      end
  end
  // slots strictly after the matched checkpoint up to and including head are discarded
  always_comb begin
    kill = '0;
    for (int k = 0; k < NUM_CKPT; k++)
      kill[k] = flush_hit && ((CW'(k) - m - CW'(1)) < (head - m));
  end
  // oldest-to-newest scan so the newest dirty slot wins
  always_comb begin
    la[0] = bus.Dis_CfcRsAddr;
    la[1] = bus.Dis_CfcRtAddr;
    la[2] = bus.Dis_CfcRdAddr;
    for (int j = 0; j < 3; j++) begin
      lr[j] = (fwd && bus.Rob_CommitRdAddr == la[j]) ? bus.Rob_CommitCurrPhyAddr : rrat[la[j]];
      for (int k = 0; k < NUM_CKPT; k++)
        if ((CW+1)'(k) <= count && dfa[tail + CW'(k)][la[j]]) lr[j] = tbl[tail + CW'(k)][la[j]];
    end
  end
  always_comb begin
    state_nx = state;
    state_nx = flush_hit ? RECOVER : NORMAL;
  end
  always_ff @(posedge clk)
    if (resetb) state <= NORMAL;
    else state <= state_nx;
  always_ff @(posedge clk)
    if (acc && bus.Dis_CfcRegWrite) tbl[head][bus.Dis_CfcRdAddr] <= bus.Dis_CfcNewRdPhyAddr;
  always_ff @(posedge clk) begin
    if (resetb) begin
      head <= '0;
      tail <= '0;
      count <= '0;
      valid <= '0;
      miss <= 1'b0;
      lq <= '{default: '0};
      for (int k = 0; k < NUM_CKPT; k++) begin
        tag[k] <= '0;
        frl[k] <= '0;
        dfa[k] <= '0;
      end
      for (int i = 0; i < NUM_AREG; i++) rrat[i] <= PREG_W'(i);
    end else begin
      if (acc) lq <= lr;
      if (bus.Cdb_Flush) miss <= ~hit;
      if (bus.Rob_Commit && bus.Rob_CommitRegWrite) rrat[bus.Rob_CommitRdAddr] <= bus.Rob_CommitCurrPhyAddr;
      if (acc && bus.Dis_CfcRegWrite) dfa[head][bus.Dis_CfcRdAddr] <= 1'b1;
      if (ckpt) begin
        tag[head] <= bus.Dis_CfcBranchTag;
        frl[head] <= bus.Frl_HeadPtr;
        valid[head] <= 1'b1;
        dfa[head + CW'(1)] <= '0;
      end
      if (rel) begin
        valid[tail] <= 1'b0;
        dfa[tail] <= '0;
      end
      for (int k = 0; k < NUM_CKPT; k++)
        if (kill[k]) begin
          valid[k] <= 1'b0;
          dfa[k] <= '0;
        end
      head <= ckpt ? head + CW'(1) : flush_hit ? m + CW'(1) : head;
      tail <= tail + CW'(rel);
      count <= flush_hit ? (CW+1)'(m - tail) + (CW+1)'(1) - (CW+1)'(rel)
                         : count + (CW+1)'(ckpt) - (CW+1)'(rel);
    end
  end
  assign bus.Cfc_RsPhyAddr = lq[0];
  assign bus.Cfc_RtPhyAddr = lq[1];
  assign bus.Cfc_RdPhyAddr = lq[2];
  assign bus.Cfc_Full = full;
  assign bus.Cfc_Busy = state == RECOVER;
  assign bus.Cfc_RobTag = tag[m];
  assign bus.Cfc_FrlHeadPtr = frl[m];
  assign bus.Cfc_CkptCount = count;
  assign bus.Cfc_FlushMiss = miss;
endmodule
